// File: rtl/mdr_unit.sv
// mdr_unit: memory data register unit.
// Sequences one byte/halfword/word load or store onto a simple req/ack memory
// port, steering lanes little-endian, and captures load data (sign- or
// zero-extended) into the mdr register. Misaligned requests and requests that
// see no ack within TIMEOUT access cycles complete with err=1.
module mdr_unit #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] MDR_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] mdr,
  output logic        done,
  output logic        err,
  output logic        busy
);

  // Last counter value at which an ACCESS cycle may still receive its ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Request fields captured when an access is accepted.
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [1:0]  addr_reg;
  logic [31:0] wdata_reg;

  logic [7:0]  cnt_reg;
  logic        err_reg;
  logic [31:0] mdr_reg;

  logic        accept;
  logic        misaligned;
  logic        timeout_hit;
  logic        ack_seen;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [3:0]  be_calc;
  logic [31:0] wd_byte_rep;
  logic [31:0] wd_half_rep;
  logic [31:0] wd_calc;

  assign accept      = (state_reg == IDLE) && start;
  assign timeout_hit = (cnt_reg == CNT_LAST);
  assign ack_seen    = (state_reg == ACCESS) && mem_ack;

  // Alignment check on the live inputs, used only at acceptance.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: ack wins over timeout in the last allowed cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = misaligned ? FIN : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack || timeout_hit) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= 2'b00;
      wdata_reg <= 32'h0000_0000;
    end else if (accept) begin
      we_reg    <= we;
      size_reg  <= size;
      uns_reg   <= uns;
      addr_reg  <= addr_lo;
      wdata_reg <= wdata;
    end
  end

  // Wait counter: cleared on acceptance, advanced on each ack-less ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (accept) begin
      cnt_reg <= 8'd0;
    end else if ((state_reg == ACCESS) && !mem_ack && !timeout_hit) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // Error flag, decided on the edge that enters FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= misaligned;
    end else if (state_reg == ACCESS) begin
      err_reg <= !mem_ack && timeout_hit;
    end
  end

  // Load-lane selection and extension from the registered request.
  always_comb begin
    byte_lane = mem_rdata[{addr_reg, 3'b000} +: 8];
    half_lane = mem_rdata[{addr_reg[1], 4'b0000} +: 16];
    load_val  = mem_rdata;
    case (size_reg)
      2'b00:   load_val = {{24{byte_lane[7] & ~uns_reg}}, byte_lane};
      2'b01:   load_val = {{16{half_lane[15] & ~uns_reg}}, half_lane};
      default: load_val = mem_rdata;
    endcase
  end

  // MDR: updated only by a load completing with ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdr_reg <= MDR_RST;
    end else if (ack_seen && !we_reg) begin
      mdr_reg <= load_val;
    end
  end

  // Replicate store data across the lanes it may land in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wd_rep
    assign wd_byte_rep[8*gi +: 8] = wdata_reg[7:0];
    assign wd_half_rep[8*gi +: 8] = wdata_reg[8*(gi % 2) +: 8];
  end

  // Byte enables and write data for the registered request.
  always_comb begin
    be_calc = 4'b0000;
    wd_calc = 32'h0000_0000;
    case (size_reg)
      2'b00: begin
        be_calc = 4'b0001 << addr_reg;
        wd_calc = wd_byte_rep;
      end
      2'b01: begin
        be_calc = 4'b0011 << addr_reg;
        wd_calc = wd_half_rep;
      end
      2'b10: begin
        be_calc = 4'b1111;
        wd_calc = wdata_reg;
      end
      default: begin
        be_calc = 4'b0000;
        wd_calc = 32'h0000_0000;
      end
    endcase
  end

  // Outputs decoded from state; the memory bus is zero outside ACCESS.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0000_0000;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state_reg != IDLE);
    mdr       = mdr_reg;
    if (state_reg == ACCESS) begin
      mem_req   = 1'b1;
      mem_we    = we_reg;
      mem_be    = be_calc;
      mem_wdata = wd_calc;
    end
    if (state_reg == FIN) begin
      done = 1'b1;
      err  = err_reg;
    end
  end

endmodule
